// File: rtl/timer_csr.sv
// CSR-mapped 32-bit timer with compare match, auto-restart and a level interrupt.
// Optional prescaler register at index 4 is enabled by defining TIMER_PRESCALER_EN.
module timer_csr #(
  parameter logic [3:0] csr_addr = 4'h3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_COMPARE  = 3'd1;
  localparam logic [2:0] REG_COUNTER  = 3'd2;
  localparam logic [2:0] REG_STATUS   = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  logic        en, ar, ie, pend;
  logic [31:0] compare, counter;
  logic [31:0] rdata;
  logic        sel, tick, match;
  logic        wr_ctrl, wr_compare, wr_counter, wr_status;
  logic [2:0]  idx;

  // Address bits between the bank field and the register index are don't-care.
  logic unused_addr;
  assign unused_addr = ^csr_a[9:3];

  assign sel        = (csr_a[13:10] == csr_addr);
  assign idx        = csr_a[2:0];
  assign wr_ctrl    = sel && csr_we && (idx == REG_CTRL);
  assign wr_compare = sel && csr_we && (idx == REG_COMPARE);
  assign wr_counter = sel && csr_we && (idx == REG_COUNTER);
  assign wr_status  = sel && csr_we && (idx == REG_STATUS);

`ifdef TIMER_PRESCALER_EN
  logic [15:0] prescale, ps_cnt;
  logic        wr_prescale;

  assign wr_prescale = sel && csr_we && (idx == REG_PRESCALE);
  assign tick        = en && (ps_cnt == prescale);
`else
  assign tick        = en;
`endif

  assign match = tick && (counter == compare);
  assign irq   = pend && ie;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    rdata = 32'd0;
    case (idx)
      REG_CTRL:     rdata = {29'd0, ie, ar, en};
      REG_COMPARE:  rdata = compare;
      REG_COUNTER:  rdata = counter;
      REG_STATUS:   rdata = {31'd0, pend};
`ifdef TIMER_PRESCALER_EN
      REG_PRESCALE: rdata = {16'd0, prescale};
`endif
      default:      rdata = 32'd0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every update sees the pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      en      <= 1'b0;
      ar      <= 1'b0;
      ie      <= 1'b0;
      compare <= 32'd0;
      counter <= 32'd0;
      pend    <= 1'b0;
      csr_do  <= 32'd0;
`ifdef TIMER_PRESCALER_EN
      prescale <= 16'd0;
      ps_cnt   <= 16'd0;
`endif
    end else begin
      csr_do <= sel ? rdata : 32'd0;

      // A CTRL write overrides the one-shot EN clear from a coincident match.
      if (wr_ctrl) begin
        en <= csr_di[0];
        ar <= csr_di[1];
        ie <= csr_di[2];
      end else if (match && !ar) begin
        en <= 1'b0;
      end

      if (wr_compare)
        compare <= csr_di;

      if (wr_counter)
        counter <= csr_di;
      else if (match)
        counter <= ar ? 32'd0 : counter;
      else if (tick)
        counter <= counter + 32'd1;

      // Set beats write-1-to-clear when both land in the same cycle.
      if (match)
        pend <= 1'b1;
      else if (wr_status && csr_di[0])
        pend <= 1'b0;

`ifdef TIMER_PRESCALER_EN
      if (wr_prescale)
        prescale <= csr_di[15:0];

      if (wr_ctrl)
        ps_cnt <= 16'd0;
      else if (en)
        ps_cnt <= tick ? 16'd0 : ps_cnt + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_timer_csr.sv
// Self-checking bench for timer_csr: a cycle-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_timer_csr;

  localparam logic [3:0] BANK = 4'h3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a   = 14'd0;
  logic        csr_we  = 1'b0;
  logic [31:0] csr_di  = 32'd0;
  logic [31:0] csr_do;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_csr #(.csr_addr(BANK)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_di  (csr_di),
    .csr_do  (csr_do),
    .irq     (irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register file as the programmer sees it, advanced one cycle per edge.
  logic        m_valid = 1'b0;
  logic        m_en, m_ar, m_ie, m_pend;
  logic [31:0] m_cmp, m_cnt, m_do;
  logic [15:0] m_ps, m_pc;

  function automatic logic [31:0] model_read(input logic [2:0] i);
    case (i)
      3'd0: return {29'd0, m_ie, m_ar, m_en};
      3'd1: return m_cmp;
      3'd2: return m_cnt;
      3'd3: return {31'd0, m_pend};
`ifdef TIMER_PRESCALER_EN
      3'd4: return {16'd0, m_ps};
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge sys_clk) begin
    logic        sel, w, tick, hit;
    logic [2:0]  i;
    sel = (csr_a[13:10] == BANK);
    i   = csr_a[2:0];
    w   = sel && csr_we;
    if (sys_rst) begin
      {m_en, m_ar, m_ie, m_pend} = 4'b0;
      m_cmp = 0; m_cnt = 0; m_do = 0; m_ps = 0; m_pc = 0;
      m_valid = 1'b1;
    end else begin
      m_do = sel ? model_read(i) : 32'd0;
`ifdef TIMER_PRESCALER_EN
      tick = m_en && (m_pc == m_ps);
      if (w && i == 3'd0) m_pc = 0;
      else if (m_en) m_pc = tick ? 16'd0 : m_pc + 16'd1;
      if (w && i == 3'd4) m_ps = csr_di[15:0];
`else
      tick = m_en;
`endif
      hit = tick && (m_cnt == m_cmp);
      if (hit) m_pend = 1'b1;
      else if (w && i == 3'd3 && csr_di[0]) m_pend = 1'b0;
      if (w && i == 3'd2) m_cnt = csr_di;
      else if (hit && m_ar) m_cnt = 0;
      else if (tick && !hit) m_cnt = m_cnt + 1;
      if (w && i == 3'd0) {m_ie, m_ar, m_en} = csr_di[2:0];
      else if (hit && !m_ar) m_en = 1'b0;
      if (w && i == 3'd1) m_cmp = csr_di;
    end
  end

  always @(negedge sys_clk) begin
    if (m_valid) begin
      check("model_csr_do", csr_do, m_do);
      check("model_irq", {31'd0, irq}, {31'd0, m_pend & m_ie});
    end
  end

  // All tasks start and end on a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wr(input logic [2:0] i, input logic [31:0] d);
    csr_a = {BANK, 7'd0, i}; csr_we = 1'b1; csr_di = d;
    @(negedge sys_clk);
    csr_a = 14'd0; csr_we = 1'b0; csr_di = 32'd0;
  endtask

  task automatic rd(input logic [2:0] i, input logic [31:0] exp, input string name);
    csr_a = {BANK, 7'd0, i};
    @(negedge sys_clk);
    check(name, csr_do, exp);
    csr_a = 14'd0;
  endtask

  initial begin
    idle(2);
    sys_rst = 1'b0;
    idle(1);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rd(3'd2, 32'd0, "reset_counter");

    // Auto-restart with interrupt: period COMPARE+1.
    wr(3'd1, 32'd4);
    wr(3'd0, 32'h7);
    idle(4);
    check("ar_irq_early", {31'd0, irq}, 32'd0);
    idle(1);
    check("ar_irq_at5", {31'd0, irq}, 32'd1);
    rd(3'd2, 32'd0, "ar_counter_wrapped");
    wr(3'd3, 32'd1);
    idle(2);
    check("ar_irq_cleared", {31'd0, irq}, 32'd0);
    idle(1);
    check("ar_irq_at10", {31'd0, irq}, 32'd1);
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd1);

    // One-shot without interrupt enable.
    wr(3'd1, 32'd2);
    wr(3'd0, 32'h1);
    idle(5);
    rd(3'd0, 32'd0, "os_ctrl_en_cleared");
    rd(3'd2, 32'd2, "os_counter_holds");
    rd(3'd3, 32'd1, "os_status_pend");
    check("os_irq_masked", {31'd0, irq}, 32'd0);

    // Counter wrap through 0xFFFFFFFF.
    wr(3'd3, 32'd1);
    wr(3'd2, 32'hFFFF_FFFE);
    wr(3'd1, 32'h10);
    wr(3'd0, 32'h1);
    idle(1);
    rd(3'd2, 32'hFFFF_FFFF, "wrap_max");
    rd(3'd2, 32'd0, "wrap_zero");
    idle(16);
    rd(3'd3, 32'd1, "wrap_match_pend");
    rd(3'd0, 32'd0, "wrap_oneshot_off");
    rd(3'd2, 32'h10, "wrap_counter_at_compare");

    // Write-1-clear coinciding with a match: set wins.
    wr(3'd3, 32'd1);
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd2);
    wr(3'd0, 32'h7);
    idle(2);
    wr(3'd3, 32'd1);
    check("w1c_vs_match_first", {31'd0, irq}, 32'd1);
    idle(2);
    wr(3'd3, 32'd1);
    check("w1c_vs_match_second", {31'd0, irq}, 32'd1);
    wr(3'd0, 32'h3);
    check("ie_off_irq_low", {31'd0, irq}, 32'd0);
    rd(3'd3, 32'd1, "ie_off_pend_kept");

    // Accesses to another bank are ignored and read 0.
    csr_a = {4'h5, 7'd0, 3'd1}; csr_we = 1'b1; csr_di = 32'hDEAD_BEEF;
    @(negedge sys_clk);
    csr_we = 1'b0;
    @(negedge sys_clk);
    check("other_bank_reads_zero", csr_do, 32'd0);
    csr_a = 14'd0;
    rd(3'd1, 32'd2, "other_bank_write_ignored");

    // Reset mid-count.
    wr(3'd0, 32'd0);
    wr(3'd3, 32'd1);
    wr(3'd1, 32'd10);
    wr(3'd2, 32'd0);
    wr(3'd0, 32'h7);
    idle(3);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_do", csr_do, 32'd0);
    rd(3'd0, 32'd0, "rst_ctrl");
    rd(3'd1, 32'd0, "rst_compare");
    rd(3'd2, 32'd0, "rst_counter");
    rd(3'd3, 32'd0, "rst_status");
    idle(3);
    rd(3'd2, 32'd0, "rst_counter_frozen");
    rd(3'd5, 32'd0, "unused_index");

`ifdef TIMER_PRESCALER_EN
    wr(3'd4, 32'hABCD_0003);
    rd(3'd4, 32'd3, "prescale_readback");
    wr(3'd1, 32'd1);
    wr(3'd0, 32'h5);
    idle(7);
    check("ps_irq_early", {31'd0, irq}, 32'd0);
    idle(1);
    check("ps_irq_at8", {31'd0, irq}, 32'd1);
`else
    wr(3'd4, 32'h1234);
    rd(3'd4, 32'd0, "index4_reads_zero");
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
